// File: rtl/sched_8_32_pkg.sv
// pkg_8_32: shared constants, FSM state encoding and the byte-placement helper
// for the sched_8_32 scheduler / word packer.
//   BYTE_W, WORD_W, BYTES_PER_WORD : datapath geometry
//   IDLE, PACK, HOLD               : FSM state codes
//   place_byte()                   : writes one byte into a word slot
//                                    (slot 0 = bits [31:24], slot 3 = bits [7:0])
package pkg_8_32;

    localparam int BYTE_W         = 8;
    localparam int WORD_W         = 32;
    localparam int BYTES_PER_WORD = 4;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] PACK = 2'd1;
    localparam logic [1:0] HOLD = 2'd2;

    // First byte of a word lands in the most significant slot.
    function automatic logic [WORD_W-1:0] place_byte(
        input logic [WORD_W-1:0] word,
        input logic [1:0]        slot,
        input logic [BYTE_W-1:0] data
    );
        logic [WORD_W-1:0] w;
        w = word;
        case (slot)
            2'd0:    w[31:24] = data;
            2'd1:    w[23:16] = data;
            2'd2:    w[15:8]  = data;
            default: w[7:0]   = data;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/sched_8_32_if.sv
// sched_8_32_if: byte-producer and word-consumer signals of the scheduler.
//   in8 / in_data8 / in_rdy8                   : per-requester byte handshake
//   out32 / out_data32 / out_id / out_nbytes   : packed word output
//   out_ready                                  : consumer accept
// modport slave  : the scheduler side
// modport master : the producers/consumer side
interface sched_8_32_if
    import pkg_8_32::*;
#(
    parameter int NREQ = 2,
    parameter int IDW  = 1
);
    logic [NREQ-1:0]        in8;
    logic [BYTE_W*NREQ-1:0] in_data8;
    logic [NREQ-1:0]        in_rdy8;
    logic                   out32;
    logic [WORD_W-1:0]      out_data32;
    logic [IDW-1:0]         out_id;
    logic [2:0]             out_nbytes;
    logic                   out_ready;

    modport slave (
        input  in8, in_data8, out_ready,
        output in_rdy8, out32, out_data32, out_id, out_nbytes
    );

    modport master (
        output in8, in_data8, out_ready,
        input  in_rdy8, out32, out_data32, out_id, out_nbytes
    );

endinterface

// File: rtl/sched_8_32_rr_arbiter.sv
// rr_arbiter: combinational rotate-priority picker.
//   req        : request vector
//   last_grant : index granted last; search starts at last_grant+1 with wrap
//   gnt        : one-hot grant (all zero when no request)
//   gnt_idx    : index of the granted requester
//   gnt_valid  : at least one request present
module rr_arbiter #(
    parameter int NREQ = 2,
    parameter int IDW  = 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  last_grant,
    output logic [NREQ-1:0] gnt,
    output logic [IDW-1:0]  gnt_idx,
    output logic            gnt_valid
);

    // cand_idx[k] is the requester at rotation distance k+1 from last_grant,
    // so cand_idx[0] has the highest priority and cand_idx[NREQ-1] == last_grant.
    logic [IDW-1:0] cand_idx [NREQ];

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_cand
            assign cand_idx[gi] = IDW'((32'(last_grant) + gi + 1) % NREQ);
        end
    endgenerate

    always_comb begin
        gnt       = '0;
        gnt_idx   = '0;
        gnt_valid = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (!gnt_valid && req[cand_idx[i]]) begin
                gnt_valid = 1'b1;
                gnt_idx   = cand_idx[i];
            end
        end
        if (gnt_valid) begin
            gnt[gnt_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/sched_8_32.sv
// sched_8_32: round-robin scheduler and 8->32 word packer.
// One requester is granted for a whole word; bytes are packed MSB-first,
// the word is tagged with source index and byte count, and a partial word
// is flushed after TIMEOUT idle cycles.
//   clk   : clock, all logic on posedge
//   reset : asynchronous, active-low
//   bus   : sched_8_32_if.slave (byte inputs, word output, handshakes)
module sched_8_32
    import pkg_8_32::*;
#(
    parameter int NREQ    = 2,
    parameter int IDW     = 1,
    parameter int TIMEOUT = 16
) (
    input  logic         clk,
    input  logic         reset,
    sched_8_32_if.slave  bus
);

    localparam int            TW         = $clog2(TIMEOUT);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

    logic [1:0]        state_q, state_d;
    logic [IDW-1:0]    grant_q, grant_d;
    logic [IDW-1:0]    last_grant_q, last_grant_d;
    logic [1:0]        cnt_q, cnt_d;
    logic [TW-1:0]     timer_q, timer_d;
    logic [WORD_W-1:0] word_q, word_d;
    logic              out32_q, out32_d;
    logic [WORD_W-1:0] out_data_q, out_data_d;
    logic [IDW-1:0]    out_id_q, out_id_d;
    logic [2:0]        out_nbytes_q, out_nbytes_d;

    logic [NREQ-1:0]   in_rdy;
    logic [NREQ-1:0]   grant_onehot;
    logic [NREQ-1:0]   arb_gnt;
    logic [IDW-1:0]    arb_idx;
    logic              arb_valid;
    logic              pack_xfer;
    logic              word_full;
    logic              timed_out;

    // Per-requester byte lanes.
    logic [BYTE_W-1:0] in_byte [NREQ];

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_lane
            assign in_byte[gi] = bus.in_data8[gi*BYTE_W +: BYTE_W];
        end
    endgenerate

    rr_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_arb (
        .req        (bus.in8),
        .last_grant (last_grant_q),
        .gnt        (arb_gnt),
        .gnt_idx    (arb_idx),
        .gnt_valid  (arb_valid)
    );

    always_comb begin
        grant_onehot          = '0;
        grant_onehot[grant_q] = 1'b1;
    end

    // Only meaningful while in PACK.
    assign pack_xfer = bus.in8[grant_q];
    assign word_full = pack_xfer && (cnt_q == 2'd3);
    assign timed_out = !pack_xfer && (timer_q == TIMER_LAST);

    // State register and all other flops.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            last_grant_q <= IDW'(NREQ - 1);
            cnt_q        <= '0;
            timer_q      <= '0;
            word_q       <= '0;
            out32_q      <= 1'b0;
            out_data_q   <= '0;
            out_id_q     <= '0;
            out_nbytes_q <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
            timer_q      <= timer_d;
            word_q       <= word_d;
            out32_q      <= out32_d;
            out_data_q   <= out_data_d;
            out_id_q     <= out_id_d;
            out_nbytes_q <= out_nbytes_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (arb_valid) state_d = PACK;
            PACK:    if (word_full || timed_out) state_d = HOLD;
            HOLD:    if (bus.out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output logic. Ready is combinational so byte 0 moves in the
    // arbitration cycle; it is forced low while reset is held.
    always_comb begin
        in_rdy = '0;
        if (reset) begin
            case (state_q)
                IDLE:    in_rdy = arb_gnt;
                PACK:    in_rdy = grant_onehot;
                default: in_rdy = '0;
            endcase
        end
    end

    assign bus.in_rdy8    = in_rdy;
    assign bus.out32      = out32_q;
    assign bus.out_data32 = out_data_q;
    assign bus.out_id     = out_id_q;
    assign bus.out_nbytes = out_nbytes_q;

    // Datapath: grant, byte counter, idle timer, word and output registers.
    always_comb begin
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;
        timer_d      = timer_q;
        word_d       = word_q;
        out32_d      = out32_q;
        out_data_d   = out_data_q;
        out_id_d     = out_id_q;
        out_nbytes_d = out_nbytes_q;
        case (state_q)
            IDLE: begin
                if (arb_valid) begin
                    grant_d = arb_idx;
                    cnt_d   = 2'd1;
                    timer_d = '0;
                    // Starting from zero leaves unfilled slots at 8'h00.
                    word_d  = place_byte('0, 2'd0, in_byte[arb_idx]);
                end
            end
            PACK: begin
                if (pack_xfer) begin
                    word_d  = place_byte(word_q, cnt_q, in_byte[grant_q]);
                    cnt_d   = cnt_q + 2'd1;
                    timer_d = '0;
                    if (cnt_q == 2'd3) begin
                        out32_d      = 1'b1;
                        out_data_d   = word_d;
                        out_id_d     = grant_q;
                        out_nbytes_d = 3'd4;
                    end
                end else if (timed_out) begin
                    out32_d      = 1'b1;
                    out_data_d   = word_q;
                    out_id_d     = grant_q;
                    out_nbytes_d = {1'b0, cnt_q};
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            HOLD: begin
                if (bus.out_ready) begin
                    out32_d      = 1'b0;
                    last_grant_d = grant_q;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_sched_8_32.sv
// tb_sched_8_32: directed table-driven bench for sched_8_32 (NREQ=2, TIMEOUT=16),
// plus hand-written sequences for timeout, back-pressure and mid-word reset.
module tb_sched_8_32;

    localparam int NREQ    = 2;
    localparam int IDW     = 1;
    localparam int TIMEOUT = 16;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    sched_8_32_if #(.NREQ(NREQ), .IDW(IDW)) bus_if ();

    sched_8_32 #(
        .NREQ    (NREQ),
        .IDW     (IDW),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [1:0]  in8;
        logic [7:0]  d0;
        logic [7:0]  d1;
        logic        rdy_out;
        logic [1:0]  exp_rdy;
        logic        exp_v;
        logic [31:0] exp_data;
        logic [0:0]  exp_id;
        logic [2:0]  exp_nb;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic [1:0] in8, input logic [7:0] d0,
                                input logic [7:0] d1, input logic rdy_out,
                                input logic [1:0] exp_rdy, input logic exp_v,
                                input logic [31:0] exp_data, input logic [0:0] exp_id,
                                input logic [2:0] exp_nb);
        vec_t v;
        v.in8 = in8; v.d0 = d0; v.d1 = d1; v.rdy_out = rdy_out;
        v.exp_rdy = exp_rdy; v.exp_v = exp_v; v.exp_data = exp_data;
        v.exp_id = exp_id; v.exp_nb = exp_nb;
        vecs.push_back(v);
    endfunction

    // One full word with both requesters streaming: 4 byte cycles then HOLD.
    function automatic void add_word(input logic [0:0] id, input logic [31:0] data);
        logic [1:0] oh;
        oh = (id == 1'b1) ? 2'b10 : 2'b01;
        for (int i = 0; i < 4; i++) add(2'b11, 8'h11, 8'h22, 1'b1, oh, 1'b0, 32'h0, 1'b0, 3'd0);
        add(2'b11, 8'h11, 8'h22, 1'b1, 2'b00, 1'b1, data, id, 3'd4);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_word(input string name, input logic [31:0] data,
                            input logic [0:0] id, input logic [2:0] nb);
        chk({name, " out32"}, 32'(bus_if.out32), 32'd1);
        chk({name, " data"}, bus_if.out_data32, data);
        chk({name, " id"}, 32'(bus_if.out_id), 32'(id));
        chk({name, " nbytes"}, 32'(bus_if.out_nbytes), 32'(nb));
        $display("word %s: id=%0d data=%h nbytes=%0d", name, bus_if.out_id,
                 bus_if.out_data32, bus_if.out_nbytes);
    endtask

    task automatic drive(input logic [1:0] in8, input logic [7:0] d0, input logic [7:0] d1,
                         input logic rdy_out);
        bus_if.in8       = in8;
        bus_if.in_data8  = {d1, d0};
        bus_if.out_ready = rdy_out;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] bytes_a [4];
        logic [7:0] bytes_c [4];
        bytes_a[0] = 8'h12; bytes_a[1] = 8'h34; bytes_a[2] = 8'h56; bytes_a[3] = 8'h78;
        bytes_c[0] = 8'hC1; bytes_c[1] = 8'hC2; bytes_c[2] = 8'hC3; bytes_c[3] = 8'hC4;

        // Vector table: inputs for a cycle and the outputs expected during it.
        add(2'b01, 8'h0F, 8'h00, 1'b1, 2'b01, 1'b0, 32'h0, 1'b0, 3'd0);
        add(2'b01, 8'h0D, 8'h00, 1'b1, 2'b01, 1'b0, 32'h0, 1'b0, 3'd0);
        add(2'b01, 8'h03, 8'h00, 1'b1, 2'b01, 1'b0, 32'h0, 1'b0, 3'd0);
        add(2'b01, 8'hAA, 8'h00, 1'b1, 2'b01, 1'b0, 32'h0, 1'b0, 3'd0);
        add(2'b00, 8'h00, 8'h00, 1'b1, 2'b00, 1'b1, 32'h0F0D03AA, 1'b0, 3'd4);
        add(2'b00, 8'h00, 8'h00, 1'b1, 2'b00, 1'b0, 32'h0, 1'b0, 3'd0);
        // Last grant was 0, so rotation continues with 1.
        add_word(1'b1, 32'h22222222);
        add_word(1'b0, 32'h11111111);
        add_word(1'b1, 32'h22222222);
        add_word(1'b0, 32'h11111111);
        add(2'b00, 8'h00, 8'h00, 1'b1, 2'b00, 1'b0, 32'h0, 1'b0, 3'd0);

        // Reset state, with a request present to check ready stays low.
        drive(2'b01, 8'h55, 8'h66, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        chk("reset out32", 32'(bus_if.out32), 32'd0);
        chk("reset data", bus_if.out_data32, 32'h0);
        chk("reset id", 32'(bus_if.out_id), 32'd0);
        chk("reset nbytes", 32'(bus_if.out_nbytes), 32'd0);
        chk("reset in_rdy8", 32'(bus_if.in_rdy8), 32'd0);
        drive(2'b00, 8'h00, 8'h00, 1'b0);
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            drive(vecs[i].in8, vecs[i].d0, vecs[i].d1, vecs[i].rdy_out);
            #2;
            chk($sformatf("vec%0d in_rdy8", i), 32'(bus_if.in_rdy8), 32'(vecs[i].exp_rdy));
            chk($sformatf("vec%0d out32", i), 32'(bus_if.out32), 32'(vecs[i].exp_v));
            if (vecs[i].exp_v) begin
                chk_word($sformatf("vec%0d", i), vecs[i].exp_data, vecs[i].exp_id, vecs[i].exp_nb);
            end
        end

        // Timeout: requester 1 sends two bytes then stops.
        @(negedge clk);
        drive(2'b10, 8'h00, 8'hBE, 1'b0);
        #2 chk("to byte0 in_rdy8", 32'(bus_if.in_rdy8), 32'b10);
        @(negedge clk);
        drive(2'b10, 8'h00, 8'hEF, 1'b0);
        #2 chk("to byte1 in_rdy8", 32'(bus_if.in_rdy8), 32'b10);
        @(negedge clk);
        drive(2'b00, 8'h00, 8'h00, 1'b0);
        for (int k = 1; k <= TIMEOUT; k++) begin
            @(posedge clk);
            #1 chk($sformatf("to out32 k=%0d", k), 32'(bus_if.out32), (k == TIMEOUT) ? 32'd1 : 32'd0);
        end
        chk_word("timeout", 32'hBEEF0000, 1'b1, 3'd2);

        // Back-pressure: 10 cycles without out_ready, requests pending.
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            drive(2'b11, 8'h11, 8'h22, 1'b0);
            #2;
            chk($sformatf("stall%0d out32", k), 32'(bus_if.out32), 32'd1);
            chk($sformatf("stall%0d data", k), bus_if.out_data32, 32'hBEEF0000);
            chk($sformatf("stall%0d in_rdy8", k), 32'(bus_if.in_rdy8), 32'd0);
        end
        @(negedge clk);
        drive(2'b00, 8'h00, 8'h00, 1'b1);
        @(posedge clk);
        #1 chk("stall release out32", 32'(bus_if.out32), 32'd0);

        // Word from requester 0 so last grant becomes 0 before the reset test.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            drive(2'b01, bytes_a[i], 8'h00, 1'b1);
            #2 chk($sformatf("w0 byte%0d in_rdy8", i), 32'(bus_if.in_rdy8), 32'b01);
        end
        @(negedge clk);
        drive(2'b00, 8'h00, 8'h00, 1'b1);
        #2 chk_word("w0", 32'h12345678, 1'b0, 3'd4);

        // Reset after two bytes of a word.
        @(negedge clk);
        drive(2'b01, 8'h99, 8'h00, 1'b1);
        #2 chk("pre-reset byte0 in_rdy8", 32'(bus_if.in_rdy8), 32'b01);
        @(negedge clk);
        drive(2'b01, 8'h98, 8'h00, 1'b1);
        #2 chk("pre-reset byte1 in_rdy8", 32'(bus_if.in_rdy8), 32'b01);
        @(negedge clk);
        drive(2'b11, 8'h00, 8'h00, 1'b1);
        #2 reset = 1'b0;
        #1;
        chk("async reset out32", 32'(bus_if.out32), 32'd0);
        chk("async reset data", bus_if.out_data32, 32'h0);
        chk("async reset nbytes", 32'(bus_if.out_nbytes), 32'd0);
        chk("async reset in_rdy8", 32'(bus_if.in_rdy8), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) @(negedge clk);
            drive(2'b11, bytes_c[i], 8'h55, 1'b1);
            #2 chk($sformatf("post-reset byte%0d in_rdy8", i), 32'(bus_if.in_rdy8), 32'b01);
        end
        @(negedge clk);
        drive(2'b00, 8'h00, 8'h00, 1'b1);
        #2 chk_word("post-reset", 32'hC1C2C3C4, 1'b0, 3'd4);
        @(negedge clk);
        #2 chk("post-reset accepted out32", 32'(bus_if.out32), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sched_8_32.md
# sched_8_32

Round-robin scheduler and word packer that shares one 8→32 serial-to-parallel path among `NREQ` byte-stream requesters. It grants one requester for a whole 32-bit word, so bytes from different sources are never interleaved. It tags each word with its source and byte count, and flushes partial words on an inactivity timeout. It sits between the byte producers (the `in8`/`in_data8` side) and the word consumer (the `out32`/`out_data32` side), all on a single clock.

## Interface
- `NREQ`, 2: number of requesters (2..4).
- `IDW`, 1: width of `out_id`, equal to clog2(`NREQ`), minimum 1.
- `TIMEOUT`, 16: idle cycles allowed inside a word before a partial flush (≥2).
- `clk`  in  1  single clock; all logic on posedge.
- `reset`  in  1  asynchronous, active-low; 0 clears all state immediately.
- `in8`  in  NREQ  per-requester byte valid.
- `in_data8`  in  8*NREQ  requester i byte on bits [8i+7:8i].
- `in_rdy8`  out  NREQ  per-requester ready, at most one bit high; a byte transfers when `in8[i] & in_rdy8[i]`.
- `out32`  out  1  word valid; held until accepted.
- `out_data32`  out  32  packed word.
- `out_id`  out  IDW  index of the source requester.
- `out_nbytes`  out  3  valid bytes in the word (1..4).
- `out_ready`  in  1  consumer accept; transfer when `out32 & out_ready`.

## Operation
- FSM states:
  - IDLE:
    - Round-robin pick among set `in8` bits, searching from `last_grant+1` with wrap.
    - `in_rdy8` is one-hot on the winner (combinational), so byte 0 transfers in the same cycle.
    - Next: `grant` = winner, `cnt` = 1, go to PACK.
    - No request: stay in IDLE, `in_rdy8` = 0.
  - PACK:
    - `in_rdy8` = onehot(`grant`). Each transfer stores a byte at slot `cnt` and increments `cnt`.
    - Transfer with `cnt`==3: go to HOLD, `out_nbytes` = 4.
    - Idle timer counts cycles without a transfer and clears on any transfer.
    - Timer reaches `TIMEOUT-1`: go to HOLD, `out_nbytes` = `cnt`, unfilled slots = 8'h00.
  - HOLD:
    - `out32` = 1, `in_rdy8` = 0.
    - `out_data32`, `out_id` and `out_nbytes` stay stable.
    - On `out_ready`: `last_grant` ← `grant`, clear `out32`, go to IDLE.
- Byte order: first byte in [31:24], then [23:16], [15:8], last byte in [7:0].
- A grant holds until its word completes or times out. Other requesters wait regardless of priority.
- Requester i is never starved: after any word, every other active requester is served before i again.

## Timing
- Reset values:
  - state IDLE, `out32` 0, `out_data32` 32'h0, `out_id` 0, `out_nbytes` 0, `in_rdy8` 0.
  - `last_grant` = `NREQ-1`, so requester 0 wins the first arbitration.
- Latency: `out32` rises on the clock edge that accepts the 4th byte, i.e. it is visible in the following cycle.
- Best-case throughput is one word per 5 cycles:
  - the HOLD acceptance cycle;
  - the IDLE/byte-0 cycle;
  - three PACK cycles.
- Timeout latency: `out32` rises exactly `TIMEOUT` cycles after the last accepted byte.
- Reset mid-word or in HOLD: the partial or pending word is discarded. `out32` drops asynchronously and is never emitted.
- If `out_ready` is already high when HOLD is entered, the word transfers in its first HOLD cycle.
- `in8` dropping mid-word is legal; the word continues when `in8` returns, or times out.
- All requesters high simultaneously: pure rotation, giving grants 0,1,…,NREQ-1,0.

## Structure
- Package `pkg_8_32` holds:
  - `BYTE_W`=8, `WORD_W`=32, `BYTES_PER_WORD`=4;
  - the state encoding localparams (IDLE, PACK, HOLD).
- Sub-module `rr_arbiter`: combinational rotate-priority picker. Inputs are the request vector and `last_grant`; outputs are a one-hot grant and its index.
- Top level contains the FSM, `cnt` (2 bits), the idle timer (clog2(`TIMEOUT`) bits), the word register and the output registers.

## Test plan
- Reset then requester 0 streams 8'h0F, 8'h0D, 8'h03, 8'hAA back-to-back, with `out_ready`=1 → `out32` for 1 cycle with `out_data32`=32'h0F0D03AA, `out_id`=0, `out_nbytes`=4, one cycle after the 4th byte.
- Both requesters continuously valid, with requester 0 bytes 8'h11 and requester 1 bytes 8'h22 → words alternate 32'h11111111 (id 0) and 32'h22222222 (id 1), never mixed.
- Requester 1 sends 8'hBE, 8'hEF then stops, `TIMEOUT`=16 → `out32` 16 cycles later with 32'hBEEF0000, `out_nbytes`=2.
- `out_ready` held 0 for 10 cycles after a word completes → `out32` and the data stay stable and `in_rdy8`=0 throughout; the word is accepted on the first `out_ready`=1 cycle.
- `reset` asserted after 2 bytes of a word → outputs clear immediately. After release, the first word out contains only post-reset bytes and arbitration restarts at requester 0.
